// File: rtl/redmule_w_preloader.sv
// redmule_w_preloader
// Feeds the first W tile into the RedMulE engine. Real rows are taken from the
// W source stream, and the rest of the tile is filled with zero beats. Every
// beat goes through a one-entry registered valid/ready stage. w_loaded_o stays
// high until the controller flushes the job.
module redmule_w_preloader #(
  parameter int unsigned Height      = 4,
  parameter int unsigned NumPipeRegs = 3,
  parameter int unsigned DataW       = 128,
  parameter int unsigned CntW        = $clog2((NumPipeRegs + 1) * Height + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             start_i,
  input  logic             flush_i,
  input  logic [CntW-1:0]  rows_i,
  input  logic             w_valid_i,
  output logic             w_ready_o,
  input  logic [DataW-1:0] w_data_i,
  output logic             beat_valid_o,
  input  logic             beat_ready_i,
  output logic [DataW-1:0] beat_data_o,
  output logic             beat_pad_o,
  output logic [CntW-1:0]  beat_row_o,
  output logic             w_loaded_o,
  output logic             busy_o
);

  localparam int unsigned     Tile     = (NumPipeRegs + 1) * Height;
  localparam logic [CntW-1:0] TileC    = CntW'(Tile);
  localparam logic [CntW-1:0] TileLast = CntW'(Tile - 1);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] LOAD  = 3'd1;
  localparam logic [2:0] PAD   = 3'd2;
  localparam logic [2:0] DRAIN = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  logic [2:0]       r_state;
  logic             r_startQ;
  logic [CntW-1:0]  r_nrows;
  logic [CntW-1:0]  r_cnt;
  logic             r_beatValid;
  logic [DataW-1:0] r_beatData;
  logic             r_beatPad;
  logic [CntW-1:0]  r_beatRow;

  logic             w_free;
  logic             w_startEdge;
  logic             w_accept;
  logic             w_padBeat;
  logic             w_load;
  logic             w_lastLoad;
  logic             w_lastPad;
  logic [CntW-1:0]  w_nrowsSat;

  // The stage can take a new beat when it is empty or its beat leaves this cycle.
  // Backpressure passes straight through to the W source, so w_ready_o never
  // depends on w_valid_i.
  assign w_free      = !r_beatValid || beat_ready_i;
  assign w_ready_o   = (r_state == LOAD) && w_free;
  assign w_accept    = w_valid_i && w_ready_o;
  assign w_padBeat   = (r_state == PAD) && w_free;
  assign w_load      = w_accept || w_padBeat;
  assign w_startEdge = (r_state == IDLE) && start_i && !r_startQ;
  assign w_nrowsSat  = (rows_i > TileC) ? TileC : rows_i;
  assign w_lastLoad  = (r_cnt == r_nrows - CntW'(1));
  assign w_lastPad   = (r_cnt == TileLast);

  assign beat_valid_o = r_beatValid;
  assign beat_data_o  = r_beatData;
  assign beat_pad_o   = r_beatPad;
  assign beat_row_o   = r_beatRow;
  assign w_loaded_o   = (r_state == DONE);
  assign busy_o       = (r_state != IDLE);

  // Sequencing FSM: loads the real rows, then pads, then drains and holds DONE until flush.
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      r_state  <= IDLE;
      r_startQ <= 1'b0;
      r_nrows  <= '0;
      r_cnt    <= '0;
    end else begin
      r_startQ <= start_i;
      if (flush_i) begin
        r_state <= IDLE;
        r_nrows <= '0;
        r_cnt   <= '0;
      end else begin
        case (r_state)
          IDLE: begin
            if (w_startEdge) begin
              r_nrows <= w_nrowsSat;
              r_cnt   <= '0;
              r_state <= (w_nrowsSat != '0) ? LOAD : PAD;
            end
          end
          LOAD: begin
            if (w_accept) begin
              r_cnt <= r_cnt + CntW'(1);
              if (w_lastLoad) begin
                r_state <= (r_nrows < TileC) ? PAD : DRAIN;
              end
            end
          end
          PAD: begin
            if (w_free) begin
              r_cnt <= r_cnt + CntW'(1);
              if (w_lastPad) begin
                r_state <= DRAIN;
              end
            end
          end
          DRAIN: begin
            if (w_free) begin
              r_state <= DONE;
            end
          end
          DONE: begin
            r_state <= DONE;
          end
          default: begin
            r_state <= IDLE;
          end
        endcase
      end
    end
  end

  // Output stage: captures a source or pad beat and holds it until the engine takes it.
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i || flush_i) begin
      r_beatValid <= 1'b0;
      r_beatData  <= '0;
      r_beatPad   <= 1'b0;
      r_beatRow   <= '0;
    end else if (w_load) begin
      r_beatValid <= 1'b1;
      r_beatData  <= w_padBeat ? '0 : w_data_i;
      r_beatPad   <= w_padBeat;
      r_beatRow   <= r_cnt;
    end else if (beat_ready_i) begin
      r_beatValid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_redmule_w_preloader.sv
// tb_redmule_w_preloader
// Directed stimulus for the W preloader. Each job pushes its 16 expected beats
// into a scoreboard, and a monitor compares every beat the DUT presents
// against the front of that queue.
module tb_redmule_w_preloader;

  localparam int DataW = 128;
  localparam int CntW  = 5;
  localparam int Tile  = 16;

  typedef struct {
    logic [DataW-1:0] data;
    logic             pad;
    logic [CntW-1:0]  row;
  } beat_t;

  logic             clk = 1'b0;
  logic             rst_i = 1'b1;
  logic             clear_i = 1'b0;
  logic             start_i = 1'b0;
  logic             flush_i = 1'b0;
  logic [CntW-1:0]  rows_i = '0;
  logic             w_valid_i = 1'b0;
  logic             w_ready_o;
  logic [DataW-1:0] w_data_i = '0;
  logic             beat_valid_o;
  logic             beat_ready_i = 1'b0;
  logic [DataW-1:0] beat_data_o;
  logic             beat_pad_o;
  logic [CntW-1:0]  beat_row_o;
  logic             w_loaded_o;
  logic             busy_o;

  int    applied = 0;
  int    miscompares = 0;
  int    inIdx = 0;
  int    curJob = 0;
  int    nExp = 0;
  int    cyc = 0;
  beat_t sb[$];

  redmule_w_preloader dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .clear_i      (clear_i),
    .start_i      (start_i),
    .flush_i      (flush_i),
    .rows_i       (rows_i),
    .w_valid_i    (w_valid_i),
    .w_ready_o    (w_ready_o),
    .w_data_i     (w_data_i),
    .beat_valid_o (beat_valid_o),
    .beat_ready_i (beat_ready_i),
    .beat_data_o  (beat_data_o),
    .beat_pad_o   (beat_pad_o),
    .beat_row_o   (beat_row_o),
    .w_loaded_o   (w_loaded_o),
    .busy_o       (busy_o)
  );

  always #5 clk = ~clk;

  function automatic logic [DataW-1:0] pattern(input int job, input int idx);
    pattern = {4{job[15:0], idx[15:0]}};
  endfunction

  task automatic checkOutput(input string tag, input logic [DataW-1:0] obs, input logic [DataW-1:0] exp);
    applied++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Queues the expected tile and raises the start level at the next negedge.
  task automatic startJob(input int rows, input int job);
    beat_t b;
    nExp   = (rows > Tile) ? Tile : rows;
    curJob = job;
    inIdx  = 0;
    for (int i = 0; i < Tile; i++) begin
      b.data = (i < nExp) ? pattern(job, i) : '0;
      b.pad  = (i >= nExp);
      b.row  = CntW'(i);
      sb.push_back(b);
    end
    @(negedge clk);
    start_i      = 1'b1;
    rows_i       = CntW'(rows);
    w_valid_i    = 1'b0;
    beat_ready_i = 1'b1;
  endtask

  // One cycle of source/sink activity; inputs change at negedge, handshakes are sampled 2ns later.
  task automatic applyStimulus(input int vProb, input int rProb);
    @(negedge clk);
    w_valid_i    = ($urandom_range(99) < vProb);
    w_data_i     = pattern(curJob, inIdx);
    beat_ready_i = ($urandom_range(99) < rProb);
    #2;
    if (w_valid_i && w_ready_o) inIdx++;
  endtask

  task automatic waitLoaded(input int vProb, input int rProb, input int budget);
    cyc = 0;
    while (!w_loaded_o && cyc < budget) begin
      applyStimulus(vProb, rProb);
      cyc++;
    end
  endtask

  task automatic finishJob(input string tag, input int expHs, input bit doFlush);
    checkOutput({tag, "_loaded"}, DataW'(w_loaded_o), DataW'(1));
    checkOutput({tag, "_in_handshakes"}, DataW'(inIdx), DataW'(expHs));
    checkOutput({tag, "_beats_left"}, DataW'(sb.size()), DataW'(0));
    if (doFlush) begin
      @(negedge clk);
      start_i   = 1'b0;
      flush_i   = 1'b1;
      w_valid_i = 1'b0;
      @(negedge clk);
      flush_i = 1'b0;
      #2;
      checkOutput({tag, "_flush_loaded"}, DataW'(w_loaded_o), DataW'(0));
      checkOutput({tag, "_flush_busy"}, DataW'(busy_o), DataW'(0));
    end
  endtask

  // Scoreboard monitor: checks every presented beat and the backpressure rule.
  always @(negedge clk) begin
    #2;
    if (!rst_i) begin
      if (beat_valid_o && !beat_ready_i) begin
        checkOutput("wready_under_stall", DataW'(w_ready_o), DataW'(0));
      end
      if (beat_valid_o) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_beat", DataW'(beat_valid_o), DataW'(0));
        end else begin
          checkOutput("beat_data", beat_data_o, sb[0].data);
          checkOutput("beat_pad", DataW'(beat_pad_o), DataW'(sb[0].pad));
          checkOutput("beat_row", DataW'(beat_row_o), DataW'(sb[0].row));
          if (beat_ready_i) void'(sb.pop_front());
        end
      end
    end
  end

  // Directed sequence covering reset, tile shapes, backpressure, flush, DONE hold and clear.
  initial begin
    repeat (3) @(negedge clk);
    rst_i = 1'b0;
    #2;
    checkOutput("rst_valid", DataW'(beat_valid_o), DataW'(0));
    checkOutput("rst_wready", DataW'(w_ready_o), DataW'(0));
    checkOutput("rst_data", beat_data_o, '0);
    checkOutput("rst_pad", DataW'(beat_pad_o), DataW'(0));
    checkOutput("rst_row", DataW'(beat_row_o), DataW'(0));
    checkOutput("rst_loaded", DataW'(w_loaded_o), DataW'(0));
    checkOutput("rst_busy", DataW'(busy_o), DataW'(0));

    startJob(16, 1);
    waitLoaded(100, 100, 100);
    checkOutput("full_loaded_cycle", DataW'(cyc), DataW'(18));
    finishJob("full", 16, 1'b1);

    startJob(5, 2);
    waitLoaded(100, 100, 100);
    finishJob("partial5", 5, 1'b1);

    startJob(0, 3);
    waitLoaded(100, 100, 100);
    finishJob("rows0", 0, 1'b1);

    startJob(20, 4);
    waitLoaded(100, 100, 100);
    finishJob("rows20", 16, 1'b1);

    startJob(16, 5);
    waitLoaded(60, 50, 400);
    finishJob("bp_full", 16, 1'b1);

    startJob(11, 6);
    waitLoaded(70, 40, 400);
    finishJob("bp_partial", 11, 1'b1);

    startJob(16, 7);
    cyc = 0;
    while (inIdx < 7 && cyc < 50) begin
      applyStimulus(100, 100);
      cyc++;
    end
    checkOutput("flush7_reached", DataW'(inIdx), DataW'(7));
    @(negedge clk);
    flush_i = 1'b1;
    start_i = 1'b0;
    @(negedge clk);
    flush_i = 1'b0;
    #2;
    checkOutput("flush7_busy", DataW'(busy_o), DataW'(0));
    checkOutput("flush7_valid", DataW'(beat_valid_o), DataW'(0));
    checkOutput("flush7_loaded", DataW'(w_loaded_o), DataW'(0));
    sb.delete();

    startJob(16, 8);
    waitLoaded(100, 100, 100);
    finishJob("after_flush", 16, 1'b0);

    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      start_i = (k % 2 == 1);
      #2;
      checkOutput("done_hold_loaded", DataW'(w_loaded_o), DataW'(1));
      checkOutput("done_hold_valid", DataW'(beat_valid_o), DataW'(0));
    end
    @(negedge clk);
    flush_i = 1'b1;
    start_i = 1'b0;
    @(negedge clk);
    flush_i = 1'b0;
    #2;
    checkOutput("done_flush_loaded", DataW'(w_loaded_o), DataW'(0));

    startJob(3, 9);
    cyc = 0;
    while (!beat_pad_o && cyc < 50) begin
      applyStimulus(100, 100);
      cyc++;
    end
    checkOutput("clear_in_pad", DataW'(beat_pad_o), DataW'(1));
    @(negedge clk);
    clear_i = 1'b1;
    start_i = 1'b0;
    @(negedge clk);
    clear_i = 1'b0;
    #2;
    checkOutput("clear_valid", DataW'(beat_valid_o), DataW'(0));
    checkOutput("clear_wready", DataW'(w_ready_o), DataW'(0));
    checkOutput("clear_data", beat_data_o, '0);
    checkOutput("clear_pad", DataW'(beat_pad_o), DataW'(0));
    checkOutput("clear_row", DataW'(beat_row_o), DataW'(0));
    checkOutput("clear_loaded", DataW'(w_loaded_o), DataW'(0));
    checkOutput("clear_busy", DataW'(busy_o), DataW'(0));
    sb.delete();

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
